// File: rtl/key_pulse_generator.sv
// ============================================================================
// key_pulse_generator
//
// Turns the four raw active-low direction pushbuttons into the one-hot step
// command word used by pixel_offset_controller. The raw buttons are first
// synchronised and debounced. Each press then becomes a single-cycle pulse,
// and a button that stays held auto-repeats: the first repeat comes after
// REPEAT_DELAY cycles and later repeats every REPEAT_PERIOD cycles. The
// offset controller therefore moves one pixel per pulse, not one per clock.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive differing cycles before a stable value flips
//   REPEAT_DELAY     cycles from the first pulse of a hold to the first repeat
//   REPEAT_PERIOD    cycles between later repeat pulses
//
// Ports:
//   clk      in   1  pixel clock, all state on the rising edge
//   rst      in   1  asynchronous active-low reset
//   btn_n    in   4  raw buttons, active-low, async to clk
//                    (bit 3 up, 2 down, 1 left, 0 right)
//   key      out  4  registered one-hot step pulse, 0000 when no step
//   pressed  out  4  debounced level, active-high (1 = held)
// ============================================================================
module key_pulse_generator #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    output logic [3:0] key,
    output logic [3:0] pressed
);

    // ------------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int DB_W      = $clog2(DEBOUNCE_CYCLES);
    localparam int TIMER_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                               : REPEAT_PERIOD;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Resets to released (1) so that a button held
    // through reset is seen as a new press once reset lifts.
    // ------------------------------------------------------------------------
    logic [3:0] sync1;
    logic [3:0] sync2;

    // NOTE: clocked state is assigned with <= so that every flop samples the
    // values from before the edge; with = the second stage would copy the
    // first stage within the same edge and the synchroniser would collapse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Debouncer: one run-length counter per bit. The counter only advances
    // while the synchronised input disagrees with the stable value. Any
    // agreeing cycle restarts the run, so only an uninterrupted run of
    // DEBOUNCE_CYCLES disagreeing cycles flips the stable value.
    // ------------------------------------------------------------------------
    logic [3:0] stable;

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [DB_W-1:0] cnt;
        logic            level;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                level <= sync2[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[i] = level;
    end

    // The stable values are flops, so the inverted level counts as registered.
    assign pressed = ~stable;

    // ------------------------------------------------------------------------
    // Direction: valid only when exactly one button is held. No press and a
    // multi-press both read as "none".
    // ------------------------------------------------------------------------
    logic [3:0] dir;

    // NOTE: dir gets a default before the case so that every path through
    // this block assigns it; otherwise synthesis would infer a latch.
    always_comb begin
        dir = 4'b0000;
        case (pressed)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: dir = pressed;
            default:                            dir = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pulse / auto-repeat FSM with one shared timer. A change of dir is
    // checked before timer expiry, so a new direction on the same edge as a
    // repeat wins and restarts the hold.
    // ------------------------------------------------------------------------
    logic [1:0]         state;
    logic [3:0]         held;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_last;

    assign timer_last = (state == S_DELAY) ? DELAY_LAST : PERIOD_LAST;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            held  <= 4'b0000;
            timer <= '0;
            key   <= 4'b0000;
        end else begin
            key <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (dir != 4'b0000) begin
                        key   <= dir;
                        held  <= dir;
                        timer <= '0;
                        state <= S_DELAY;
                    end
                end
                S_DELAY, S_REPEAT: begin
                    if (dir == 4'b0000) begin
                        state <= S_IDLE;
                    end else if (dir != held) begin
                        key   <= dir;
                        held  <= dir;
                        timer <= '0;
                        state <= S_DELAY;
                    end else if (timer == timer_last) begin
                        key   <= held;
                        timer <= '0;
                        state <= S_REPEAT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
